// File: rtl/bus_master.sv
// Byte-serial bus master: one CPU request becomes a run of address-byte phases
// and a data phase on the rdy/ack/bus_ctrl handshake bus, with an address-byte cache and a watchdog.
module bus_master #(
    parameter int ADDR_BYTES = 3,
    parameter int ADDR_CACHE = 1,
    parameter int TIMEOUT    = 1024,
    parameter int CTRL_W     = $clog2(ADDR_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*ADDR_BYTES-1:0] addr,
    input  logic [7:0]              wdata,
    output logic [7:0]              rdata,
    input  logic                    req,
    input  logic                    we,
    input  logic                    use_addr,
    output logic                    done,
    output logic                    err,
    input  logic                    ack,
    output logic                    rdy,
    output logic [CTRL_W-1:0]       bus_ctrl,
    input  logic [7:0]              bus_in,
    output logic [7:0]              bus_out
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_DRIVE,
        ADDR_WAIT,
        DATA_DRIVE,
        DATA_WAIT
    } state_t;

    state_t                  state;
    logic                    req_d;
    logic                    ack_m, ack_s, ack_s_d;
    logic [8*ADDR_BYTES-1:0] lat_addr;
    logic [7:0]              lat_wdata;
    logic                    lat_we;
    logic [CTRL_W-1:0]       idx;
    logic [CNT_W-1:0]        wait_cnt;
    logic [7:0]              cache [ADDR_BYTES];
    logic [ADDR_BYTES-1:0]   cache_valid;

    logic                    req_edge, ack_rise;
    logic [ADDR_BYTES-1:0]   need_new, need_lat;
    logic                    first_found, next_found;
    logic [CTRL_W-1:0]       first_idx, next_idx;
    logic [7:0]              cur_byte;
    logic                    wait_expired;

    assign req_edge = req & ~req_d;
    assign ack_rise = ack_s & ~ack_s_d;
    assign wait_expired = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // A byte is needed unless the cache already holds it; lookups against the
    // incoming address pick the first phase, against the latched one the next.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        need_new    = '1;
        need_lat    = '1;
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        cur_byte    = '0;
        for (int i = 0; i < ADDR_BYTES; i++) begin
            if (ADDR_CACHE != 0 && cache_valid[i]) begin
                need_new[i] = (cache[i] != addr[8*i +: 8]);
                need_lat[i] = (cache[i] != lat_addr[8*i +: 8]);
            end
            if (CTRL_W'(i) == idx)
                cur_byte = lat_addr[8*i +: 8];
        end
        for (int i = ADDR_BYTES - 1; i >= 0; i--) begin
            if (need_new[i]) begin
                first_found = 1'b1;
                first_idx   = CTRL_W'(i);
            end
            if (need_lat[i] && CTRL_W'(i) > idx) begin
                next_found = 1'b1;
                next_idx   = CTRL_W'(i);
            end
        end
    end

    // NOTE: the byte store has no reset; cache_valid alone decides whether an entry counts.
    always_ff @(posedge clk) begin
        if (state == ADDR_WAIT && ack_rise) begin
            for (int i = 0; i < ADDR_BYTES; i++)
                if (CTRL_W'(i) == idx)
                    cache[i] <= cur_byte;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req_d       <= 1'b0;
            ack_m       <= 1'b0;
            ack_s       <= 1'b0;
            ack_s_d     <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_we      <= 1'b0;
            idx         <= '0;
            wait_cnt    <= '0;
            cache_valid <= '0;
            rdy         <= 1'b0;
            bus_ctrl    <= '0;
            bus_out     <= '0;
            rdata       <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            req_d   <= req;
            ack_m   <= ack;
            ack_s   <= ack_m;
            ack_s_d <= ack_s;
            done    <= 1'b0;
            err     <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (req_edge) begin
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        lat_we    <= we;
                        if (use_addr && first_found) begin
                            idx   <= first_idx;
                            state <= ADDR_DRIVE;
                        end else begin
                            state <= DATA_DRIVE;
                        end
                    end
                end
                ADDR_DRIVE: begin
                    bus_out  <= cur_byte;
                    bus_ctrl <= idx;
                    rdy      <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ADDR_WAIT;
                end
                ADDR_WAIT: begin
                    if (ack_rise) begin
                        rdy <= 1'b0;
                        for (int i = 0; i < ADDR_BYTES; i++)
                            if (CTRL_W'(i) == idx)
                                cache_valid[i] <= 1'b1;
                        if (next_found) begin
                            idx   <= next_idx;
                            state <= ADDR_DRIVE;
                        end else begin
                            state <= DATA_DRIVE;
                        end
                    end else if (wait_expired) begin
                        rdy         <= 1'b0;
                        done        <= 1'b1;
                        err         <= 1'b1;
                        cache_valid <= '0;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DATA_DRIVE: begin
                    bus_ctrl <= CTRL_W'(ADDR_BYTES);
                    rdy      <= 1'b1;
                    if (lat_we)
                        bus_out <= lat_wdata;
                    wait_cnt <= '0;
                    state    <= DATA_WAIT;
                end
                DATA_WAIT: begin
                    if (ack_rise) begin
                        rdy  <= 1'b0;
                        done <= 1'b1;
                        if (!lat_we)
                            rdata <= bus_in;
                        state <= IDLE;
                    end else if (wait_expired) begin
                        rdy         <= 1'b0;
                        done        <= 1'b1;
                        err         <= 1'b1;
                        cache_valid <= '0;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master.sv
// Scoreboard bench for bus_master: a cache-aware transfer model predicts the phase list and
// result of each request, a monitor checks every phase and done pulse, a random slave answers.
module tb_bus_master;

    localparam int NB = 3;
    localparam int TO = 16;

    typedef struct packed {
        logic [1:0] ctrl;
        logic [7:0] out;
    } phase_t;

    typedef struct packed {
        logic       err;
        logic [7:0] rdata;
    } res_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [23:0]   addr;
    logic [7:0]    wdata, rdata, bus_in, bus_out;
    logic          req, we, use_addr, done, err, ack, rdy;
    logic [1:0]    bus_ctrl;

    logic [7:0]    a1, wd1, rd1, bus_in1, bus_out1;
    logic          req1, we1, ua1, done1, err1, ack1, rdy1;
    logic [0:0]    bus_ctrl1;

    int            n_checks = 0;
    int            n_fail   = 0;

    phase_t        phase_q [$];
    res_t          res_q [$];

    logic [7:0]    m_cache [NB];
    logic [NB-1:0] m_valid;
    logic [7:0]    m_last;
    logic [7:0]    m_rdata;

    int            phase_cnt   = 0;
    int            mute_at     = 32'h7fffffff;
    logic [7:0]    slave_rdata = 8'h00;

    logic [8:0]    obs1 [$];
    int            done1_cnt = 0;
    int            err1_cnt  = 0;

    always #5 clk = ~clk;

    bus_master #(.ADDR_BYTES(NB), .ADDR_CACHE(1), .TIMEOUT(TO)) u_dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .rdata(rdata),
        .req(req), .we(we), .use_addr(use_addr), .done(done), .err(err),
        .ack(ack), .rdy(rdy), .bus_ctrl(bus_ctrl), .bus_in(bus_in), .bus_out(bus_out)
    );

    bus_master #(.ADDR_BYTES(1), .ADDR_CACHE(0), .TIMEOUT(TO)) u_dut1 (
        .clk(clk), .reset(reset), .addr(a1), .wdata(wd1), .rdata(rd1),
        .req(req1), .we(we1), .use_addr(ua1), .done(done1), .err(err1),
        .ack(ack1), .rdy(rdy1), .bus_ctrl(bus_ctrl1), .bus_in(bus_in1), .bus_out(bus_out1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = '0;
        m_last  = 8'h00;
        m_rdata = 8'h00;
    endtask

    // Predict phases/result, then issue the request. mute_k = index of the phase the
    // slave ignores (-1: none). rst_mid: the caller resets the DUT mid-transfer.
    task automatic xfer(input logic [23:0] a, input logic w, input logic [7:0] wd,
                        input logic ua, input logic [7:0] rd, input int mute_k,
                        input bit rst_mid);
        bit aborted = 1'b0;
        int k = 0;
        int n = 0;
        if (ua) begin
            for (int i = 0; i < NB; i++) begin
                logic [7:0] b;
                b = a[8*i +: 8];
                if (aborted) break;
                if (!(m_valid[i] && m_cache[i] == b)) begin
                    phase_q.push_back('{ctrl: 2'(i), out: b});
                    m_last = b;
                    if (k == mute_k) aborted = 1'b1;
                    else begin
                        m_valid[i] = 1'b1;
                        m_cache[i] = b;
                    end
                    k++;
                end
            end
        end
        if (!aborted) begin
            phase_q.push_back('{ctrl: 2'(NB), out: w ? wd : m_last});
            if (w) m_last = wd;
            if (k == mute_k) aborted = 1'b1;
            else if (!w) m_rdata = rd;
        end
        if (!rst_mid) begin
            if (aborted) m_valid = '0;
            res_q.push_back('{err: aborted, rdata: m_rdata});
        end

        slave_rdata = rd;
        mute_at = (mute_k < 0) ? 32'h7fffffff : phase_cnt + mute_k;
        @(negedge clk);
        addr = a; we = w; wdata = wd; use_addr = ua; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("rdy_before_drive", 32'(rdy), 0);
        addr = 24'($urandom); wdata = 8'($urandom); we = 1'($urandom); use_addr = 1'($urandom);
        @(negedge clk);
        check("rdy_at_e0_plus_1", 32'(rdy), 1);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        if (!rst_mid) begin
            while (!done && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("done_seen", 32'(done), 1);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic xfer1(input logic [7:0] wd);
        int n = 0;
        @(negedge clk);
        a1 = 8'h5A; we1 = 1'b1; wd1 = wd; ua1 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        @(negedge clk);
        req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        while (!done1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("dut1_done_seen", 32'(done1), 1);
        repeat (3) @(negedge clk);
    endtask

    // Slave for the main DUT: random ack delay, drops ack only after rdy falls.
    initial begin
        ack = 1'b0;
        bus_in = 8'h00;
        forever begin
            @(negedge clk);
            if (rdy && !reset) begin
                int my;
                my = phase_cnt;
                phase_cnt++;
                if (my != mute_at) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    bus_in = (bus_ctrl == 2'(NB)) ? slave_rdata : 8'($urandom);
                    ack = 1'b1;
                end
                for (int n = 0; n < 200 && rdy; n++) @(negedge clk);
                ack = 1'b0;
            end
        end
    end

    initial begin
        ack1 = 1'b0;
        bus_in1 = 8'h00;
        forever begin
            @(negedge clk);
            if (rdy1 && !reset) begin
                ack1 = 1'b1;
                for (int n = 0; n < 200 && rdy1; n++) @(negedge clk);
                ack1 = 1'b0;
            end
        end
    end

    // Monitor: each rdy rise is one phase, each done pulse one transfer result.
    initial begin
        bit   rdy_prev = 1'b0;
        int   run_len  = 0;
        bit   rdy1_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rdy_prev  = 1'b0;
                rdy1_prev = 1'b0;
                run_len   = 0;
            end else begin
                if (rdy) run_len = rdy_prev ? run_len + 1 : 1;
                if (rdy && !rdy_prev) begin
                    check("phase_expected", 32'(phase_q.size() > 0), 1);
                    if (phase_q.size() > 0) begin
                        phase_t ph;
                        ph = phase_q.pop_front();
                        check("phase_bus_ctrl", 32'(bus_ctrl), 32'(ph.ctrl));
                        check("phase_bus_out", 32'(bus_out), 32'(ph.out));
                    end
                end
                if (err) check("err_with_done", 32'(done), 1);
                if (done) begin
                    check("result_expected", 32'(res_q.size() > 0), 1);
                    check("rdy_low_at_done", 32'(rdy), 0);
                    if (res_q.size() > 0) begin
                        res_t r;
                        r = res_q.pop_front();
                        check("result_err", 32'(err), 32'(r.err));
                        check("result_rdata", 32'(rdata), 32'(r.rdata));
                        if (r.err) check("timeout_len", 32'(run_len), TO);
                    end
                end
                rdy_prev = rdy;

                if (rdy1 && !rdy1_prev) obs1.push_back({bus_ctrl1, bus_out1});
                if (done1) done1_cnt++;
                if (err1) err1_cnt++;
                rdy1_prev = rdy1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] exp1 [4];
        logic [23:0] cur_a;
        int p0;
        int n;
        exp1 = '{9'h05A, 9'h111, 9'h05A, 9'h122};

        reset = 1'b1;
        addr = '0; wdata = '0; req = 1'b0; we = 1'b0; use_addr = 1'b0;
        a1 = '0; wd1 = '0; req1 = 1'b0; we1 = 1'b0; ua1 = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_rdy", 32'(rdy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_err", 32'(err), 0);
        check("reset_bus_ctrl", 32'(bus_ctrl), 0);
        check("reset_bus_out", 32'(bus_out), 0);
        check("reset_rdata", 32'(rdata), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        xfer(24'h123456, 1'b1, 8'hA5, 1'b1, 8'h00, -1, 1'b0);
        xfer(24'h123499, 1'b0, 8'h00, 1'b1, 8'h3C, -1, 1'b0);
        check("read_rdata", 32'(rdata), 32'h3C);
        xfer(24'h123499, 1'b0, 8'h00, 1'b0, 8'h77, -1, 1'b0);
        check("noaddr_rdata", 32'(rdata), 32'h77);

        // Timeout on the data phase, then a repeat transfer must resend every byte.
        xfer(24'h123499, 1'b1, 8'h66, 1'b1, 8'h00, 0, 1'b0);
        xfer(24'h123499, 1'b0, 8'h00, 1'b1, 8'hC3, -1, 1'b0);

        // Reset while byte 1 waits for an ack.
        p0 = phase_cnt;
        xfer(24'hABCDEF, 1'b1, 8'h42, 1'b1, 8'h00, 1, 1'b1);
        n = 0;
        while (phase_cnt < p0 + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_byte1_wait", 32'(phase_cnt - p0), 2);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset_rdy", 32'(rdy), 0);
        check("midreset_bus_ctrl", 32'(bus_ctrl), 0);
        check("midreset_bus_out", 32'(bus_out), 0);
        check("midreset_done", 32'(done), 0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("postreset_done", 32'(done), 0);
        check("postreset_rdata", 32'(rdata), 0);
        xfer(24'hABCDEF, 1'b0, 8'h00, 1'b1, 8'h5E, -1, 1'b0);

        cur_a = 24'hABCDEF;
        for (int t = 0; t < 60; t++) begin
            logic [2:0] r;
            int mk;
            r = 3'($urandom);
            cur_a = cur_a ^ (24'($urandom) & {{8{r[2]}}, {8{r[1]}}, {8{r[0]}}});
            mk = -1;
            if ($urandom_range(0, 7) == 0) mk = int'($urandom_range(0, 3));
            xfer(cur_a, 1'($urandom), 8'($urandom), ($urandom_range(0, 4) != 0),
                 8'($urandom), mk, 1'b0);
        end

        xfer1(8'h11);
        xfer1(8'h22);
        repeat (10) @(negedge clk);
        check("dut1_done_count", 32'(done1_cnt), 2);
        check("dut1_err_count", 32'(err1_cnt), 0);
        check("dut1_phase_count", 32'(obs1.size()), 4);
        for (int i = 0; i < 4; i++)
            if (i < obs1.size()) check("dut1_phase", 32'(obs1[i]), 32'(exp1[i]));

        check("phase_q_drained", 32'(phase_q.size()), 0);
        check("res_q_drained", 32'(res_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
